// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program loader: FSM state encoding and
// byte/word framing sizes.
package program_loader_pkg;

    localparam int unsigned BYTE_WIDTH     = 8;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned HEADER_BYTES   = 2;
    localparam int unsigned WORD_WIDTH     = BYTE_WIDTH * BYTES_PER_WORD;
    localparam int unsigned COUNT_WIDTH    = BYTE_WIDTH * HEADER_BYTES;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CNT_HI = 3'd1,
        S_CNT_LO = 3'd2,
        S_RECV   = 3'd3,
        S_WRITE  = 3'd4,
        S_CHK    = 3'd5,
        S_DONE   = 3'd6,
        S_ERROR  = 3'd7
    } state_e;

    // States in which the loader is willing to take a byte from the source.
    function automatic logic state_accepts_byte(input state_e s);
        return (s == S_CNT_HI) || (s == S_CNT_LO) || (s == S_RECV) || (s == S_CHK);
    endfunction

endpackage

// File: rtl/program_loader_byte_assembler.sv
// Big-endian byte-to-word assembler: collects BYTES_PER_WORD bytes, the first
// byte landing in the most significant position.
module program_loader_byte_assembler
    import program_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_i,
    input  logic                  accept_i,
    input  logic [BYTE_WIDTH-1:0] byte_i,
    output logic [WORD_WIDTH-1:0] word_c,
    output logic                  word_ready_c
);

    localparam int unsigned IDX_WIDTH   = $clog2(BYTES_PER_WORD);
    localparam int unsigned SHIFT_WIDTH = WORD_WIDTH - BYTE_WIDTH;

    logic [SHIFT_WIDTH-1:0] shift_q, shift_d;
    logic [IDX_WIDTH-1:0]   idx_q, idx_d;

    // Only the first three bytes are stored; the fourth is taken straight
    // from the input so the full word is available on the accepting cycle.
    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        if (clear_i) begin
            shift_d = '0;
            idx_d   = '0;
        end else if (accept_i) begin
            shift_d = {shift_q[SHIFT_WIDTH-BYTE_WIDTH-1:0], byte_i};
            idx_d   = idx_q + IDX_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

    assign word_c       = {shift_q, byte_i};
    assign word_ready_c = accept_i && (idx_q == IDX_WIDTH'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/program_loader.sv
// Program loader: turns a counted big-endian byte stream into program-memory
// word writes and holds the CPU in reset until the image is complete.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned             MEMORY_DEPTH = 32,
    parameter int unsigned             DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0]   BASE_ADDRESS = 32'h0040_0000,
    localparam int unsigned            CNT_WIDTH    = $clog2(MEMORY_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  mem_write,
    output logic [DATA_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_error,
    output logic [CNT_WIDTH-1:0]  words_loaded
);

`ifdef LOADER_CHECKSUM_EN
    localparam state_e END_STATE = S_CHK;
`else
    localparam state_e END_STATE = S_DONE;
`endif

    state_e                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0]   words_loaded_q;
    logic [DATA_WIDTH-1:0]  mem_address_q;
    logic [DATA_WIDTH-1:0]  mem_data_q;
    logic                   mem_write_q;
    logic                   rx_ready_q;
    logic                   cpu_hold_q;
    logic                   load_done_q;
    logic                   load_error_q;

    logic                   accept_c;
    logic                   start_ok_c;
    logic                   last_word_c;
    logic [COUNT_WIDTH-1:0] count_full_c;
    logic [WORD_WIDTH-1:0]  word_c;
    logic                   word_ready_c;

    assign accept_c     = rx_valid && rx_ready_q;
    assign start_ok_c   = start && ((state_q == S_IDLE) || (state_q == S_DONE) ||
                                    (state_q == S_ERROR));
    assign count_full_c = {count_q[COUNT_WIDTH-1:BYTE_WIDTH], rx_data};
    assign last_word_c  = (COUNT_WIDTH'(words_loaded_q) + COUNT_WIDTH'(1)) == count_q;

    program_loader_byte_assembler u_asm (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (start_ok_c),
        .accept_i     (accept_c && (state_q == S_RECV)),
        .byte_i       (rx_data),
        .word_c       (word_c),
        .word_ready_c (word_ready_c)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [BYTE_WIDTH-1:0] xor_q;

    // Running XOR over every accepted byte of the current frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            xor_q <= '0;
        end else if (start_ok_c) begin
            xor_q <= '0;
        end else if (accept_c) begin
            xor_q <= xor_q ^ rx_data;
        end
    end
`endif

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) state_d = S_CNT_HI;
            end
            S_CNT_HI: begin
                if (accept_c) state_d = S_CNT_LO;
            end
            S_CNT_LO: begin
                if (accept_c) begin
                    if (32'(count_full_c) > MEMORY_DEPTH) begin
                        state_d = S_ERROR;
                    end else if (count_full_c == '0) begin
                        state_d = END_STATE;
                    end else begin
                        state_d = S_RECV;
                    end
                end
            end
            S_RECV: begin
                if (word_ready_c) state_d = S_WRITE;
            end
            S_WRITE: begin
                state_d = last_word_c ? END_STATE : S_RECV;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                if (accept_c) begin
                    state_d = ((xor_q ^ rx_data) == '0) ? S_DONE : S_ERROR;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // State register; all outputs are registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            count_q        <= '0;
            words_loaded_q <= '0;
            mem_address_q  <= BASE_ADDRESS;
            mem_data_q     <= '0;
            mem_write_q    <= 1'b0;
            rx_ready_q     <= 1'b0;
            cpu_hold_q     <= 1'b1;
            load_done_q    <= 1'b0;
            load_error_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rx_ready_q   <= state_accepts_byte(state_d);
            mem_write_q  <= (state_d == S_WRITE);
            load_done_q  <= (state_d == S_DONE);
            load_error_q <= (state_d == S_ERROR);
            cpu_hold_q   <= (state_d != S_DONE);

            if (start_ok_c) begin
                count_q        <= '0;
                words_loaded_q <= '0;
                mem_address_q  <= BASE_ADDRESS;
            end

            if (accept_c && (state_q == S_CNT_HI)) begin
                count_q <= {rx_data, BYTE_WIDTH'(0)};
            end
            if (accept_c && (state_q == S_CNT_LO)) begin
                count_q <= count_full_c;
            end

            if ((state_q == S_RECV) && word_ready_c) begin
                mem_data_q <= DATA_WIDTH'(word_c);
            end

            // Address tracks BASE + 4*words_loaded and advances after each write.
            if (state_q == S_WRITE) begin
                words_loaded_q <= words_loaded_q + CNT_WIDTH'(1);
                mem_address_q  <= mem_address_q + DATA_WIDTH'(BYTES_PER_WORD);
            end
        end
    end

    assign rx_ready     = rx_ready_q;
    assign mem_write    = mem_write_q;
    assign mem_address  = mem_address_q;
    assign mem_data     = mem_data_q;
    assign cpu_hold     = cpu_hold_q;
    assign load_done    = load_done_q;
    assign load_error   = load_error_q;
    assign words_loaded = words_loaded_q;

endmodule
